// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and constants for the multi-cycle control unit:
//                state encoding, ALU/mux select codes, default opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Controller states; IDLE must stay at zero so reset decodes to all-off
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Default MIPS opcode encodings
    localparam logic [5:0] DEF_OP_RTYPE = 6'h00;
    localparam logic [5:0] DEF_OP_LW    = 6'h23;
    localparam logic [5:0] DEF_OP_SW    = 6'h2B;
    localparam logic [5:0] DEF_OP_BEQ   = 6'h04;
    localparam logic [5:0] DEF_OP_J     = 6'h02;
    localparam logic [5:0] DEF_OP_ADDI  = 6'h08;

endpackage
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_wait_timer
//  Description : Counts consecutive memory wait cycles and flags the cycle in
//                which one more stall would exceed MEM_TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expire
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // Count stalls while a memory access is pending; any completion or
    // leaving the memory states starts the next access from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (active && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A ready in the final allowed cycle still completes the access
    assign expire = active && !mem_ready && (wait_cnt == LAST_WAIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multi-cycle main control FSM for the MIPS-subset datapath,
//                with memory-ready timeout, illegal-opcode trap and
//                instruction-done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int              OP_W        = 6,
    parameter logic [OP_W-1:0] OP_RTYPE    = DEF_OP_RTYPE,
    parameter logic [OP_W-1:0] OP_LW       = DEF_OP_LW,
    parameter logic [OP_W-1:0] OP_SW       = DEF_OP_SW,
    parameter logic [OP_W-1:0] OP_BEQ      = DEF_OP_BEQ,
    parameter logic [OP_W-1:0] OP_J        = DEF_OP_J,
    parameter logic [OP_W-1:0] OP_ADDI     = DEF_OP_ADDI,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            AluSrcA,
    output logic [1:0]      AluSrcB,
    output logic [1:0]      AluOp,
    output logic [1:0]      PCSource,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            mem_timeout,
    output logic [3:0]      state_dbg
);

    state_t state;
    state_t state_nx;
    state_t after_final;
    logic   is_store;
    logic   op_known;
    logic   wait_active;
    logic   wait_expire;

    assign wait_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign op_known    = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                         (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    assign after_final = run ? S_FETCH : S_IDLE;
    assign state_dbg   = state;

    ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (wait_active),
        .mem_ready (mem_ready),
        .expire    (wait_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Load/store flavour is captured in DECODE because op is only valid there;
    // the error flags are sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store    <= 1'b0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                is_store <= (op == OP_SW);
                if (!op_known) begin
                    illegal_op <= 1'b1;
                end
            end
            if (wait_expire) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state selection and per-state control decode
    always_comb begin
        state_nx    = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = SRCB_B;
        AluOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                MemRead  = 1'b1;
                AluSrcB  = SRCB_FOUR;
                // PC and IR only load in the cycle the fetch completes
                PCWrite  = mem_ready;
                IRWrite  = mem_ready;
                if (mem_ready) begin
                    state_nx = S_DECODE;
                end else if (wait_expire) begin
                    state_nx = S_TRAP;
                end
            end
            S_DECODE: begin
                AluSrcB = SRCB_IMM_SH2;
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_nx = S_MEM_ADDR;
                end else if (op == OP_RTYPE) begin
                    state_nx = S_EXEC;
                end else if (op == OP_BEQ) begin
                    state_nx = S_BRANCH;
                end else if (op == OP_J) begin
                    state_nx = S_JUMP;
                end else if (op == OP_ADDI) begin
                    state_nx = S_ADDI_EX;
                end else begin
                    state_nx = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                AluSrcA  = 1'b1;
                AluSrcB  = SRCB_IMM;
                state_nx = is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_nx = S_MEM_WB;
                end else if (wait_expire) begin
                    state_nx = S_TRAP;
                end
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_nx   = after_final;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nx   = after_final;
                end else if (wait_expire) begin
                    state_nx = S_TRAP;
                end
            end
            S_EXEC: begin
                AluSrcA  = 1'b1;
                AluOp    = ALUOP_FUNCT;
                state_nx = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_nx   = after_final;
            end
            S_BRANCH: begin
                AluSrcA     = 1'b1;
                AluOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_nx    = after_final;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_nx   = after_final;
            end
            S_ADDI_EX: begin
                AluSrcA  = 1'b1;
                AluSrcB  = SRCB_IMM;
                state_nx = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_nx   = after_final;
            end
            S_TRAP: begin
                state_nx = S_TRAP;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller: directed
//                vector table, hand-written corner sequences and randomized
//                run against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    import ctrl_pkg::*;

    localparam int TMO = 4;
    localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B;
    localparam logic [5:0] BQ = 6'h04, JP = 6'h02, AI = 6'h08;

    // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
    //                IRWrite,RegWrite,RegDst,AluSrcA,AluSrcB,AluOp,PCSource}
    function automatic logic [15:0] ctl(input bit pcw, pcwc, iord, mrd, mwr, m2r,
                                        irw, rw, rdst, asa,
                                        input logic [1:0] asb, aop, pcs);
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, asb, aop, pcs};
    endfunction

    localparam logic [15:0] C_FETCH   = ctl(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    localparam logic [15:0] C_FSTROBE = ctl(1,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [15:0] C_FRDY    = C_FETCH | C_FSTROBE;
    localparam logic [15:0] C_DECODE  = ctl(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
    localparam logic [15:0] C_MADDR   = ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    localparam logic [15:0] C_MRD     = ctl(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [15:0] C_MWB     = ctl(0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [15:0] C_MWR     = ctl(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [15:0] C_EXEC    = ctl(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    localparam logic [15:0] C_RWB     = ctl(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    localparam logic [15:0] C_BR      = ctl(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
    localparam logic [15:0] C_J       = ctl(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
    localparam logic [15:0] C_AEX     = ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    localparam logic [15:0] C_AWB     = ctl(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] op = 6'h00;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, AluSrcA;
    logic [1:0] AluSrcB, AluOp, PCSource;
    logic       instr_done, illegal_op, mem_timeout;
    logic [3:0] state_dbg;
    logic [15:0] dut_ctl;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, RegWrite, RegDst, AluSrcA, AluSrcB, AluOp, PCSource};

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input state_t est, input logic [15:0] ectl,
                         input bit edone, input bit eill, input bit etmo);
        logic [22:0] act;
        logic [22:0] exp;
        act = {state_dbg, dut_ctl, instr_done, illegal_op, mem_timeout};
        exp = {4'(est), ectl, edone, eill, etmo};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @%0t: got st=%0d ctl=%h done=%b ill=%b tmo=%b, want st=%0d ctl=%h done=%b ill=%b tmo=%b",
                      name, $time, state_dbg, dut_ctl, instr_done, illegal_op, mem_timeout,
                      est, ectl, edone, eill, etmo);
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, return
    task automatic cyc(input bit r, input bit rn, input logic [5:0] o, input bit rdy);
        @(negedge clk);
        rst_n = r; run = rn; op = o; mem_ready = rdy;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         r;
        bit         rn;
        logic [5:0] o;
        bit         rdy;
        state_t     st;
        logic [15:0] c;
        bit         d;
    } vec_t;
    vec_t tbl[$];

    function automatic void v(input bit r, input bit rn, input logic [5:0] o, input bit rdy,
                              input state_t st, input logic [15:0] c, input bit d);
        vec_t x;
        x.r = r; x.rn = rn; x.o = o; x.rdy = rdy; x.st = st; x.c = c; x.d = d;
        tbl.push_back(x);
    endfunction

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        state_t      st;
        logic [15:0] c;
        bit          waits;
        bit          fin;
    } step_t;
    step_t mq[$];
    bit    m_trap, m_ill, m_tmo;
    int    m_wait;

    function automatic step_t mk(input state_t s, input logic [15:0] c, input bit w, input bit f);
        step_t x;
        x.st = s; x.c = c; x.waits = w; x.fin = f;
        return x;
    endfunction

    function automatic void m_reset();
        mq.delete(); m_trap = 0; m_ill = 0; m_tmo = 0; m_wait = 0;
    endfunction

    function automatic void m_start();
        mq.push_back(mk(S_FETCH, C_FETCH, 1, 0));
        mq.push_back(mk(S_DECODE, C_DECODE, 0, 0));
    endfunction

    // The remaining steps of an instruction once its opcode is known
    function automatic void m_expand(input logic [5:0] o);
        case (o)
            LW: begin
                mq.push_back(mk(S_MEM_ADDR, C_MADDR, 0, 0));
                mq.push_back(mk(S_MEM_RD, C_MRD, 1, 0));
                mq.push_back(mk(S_MEM_WB, C_MWB, 0, 1));
            end
            SW: begin
                mq.push_back(mk(S_MEM_ADDR, C_MADDR, 0, 0));
                mq.push_back(mk(S_MEM_WR, C_MWR, 1, 1));
            end
            RT: begin
                mq.push_back(mk(S_EXEC, C_EXEC, 0, 0));
                mq.push_back(mk(S_R_WB, C_RWB, 0, 1));
            end
            BQ: mq.push_back(mk(S_BRANCH, C_BR, 0, 1));
            JP: mq.push_back(mk(S_JUMP, C_J, 0, 1));
            AI: begin
                mq.push_back(mk(S_ADDI_EX, C_AEX, 0, 0));
                mq.push_back(mk(S_ADDI_WB, C_AWB, 0, 1));
            end
            default: begin m_trap = 1; m_ill = 1; end
        endcase
    endfunction

    function automatic void m_advance(input bit rn, input logic [5:0] o, input bit rdy);
        step_t h;
        if (m_trap) return;
        if (mq.size() == 0) begin
            if (rn) m_start();
            return;
        end
        h = mq[0];
        if (h.waits && !rdy) begin
            m_wait++;
            if (m_wait >= TMO) begin m_trap = 1; m_tmo = 1; mq.delete(); end
            return;
        end
        m_wait = 0;
        void'(mq.pop_front());
        if (h.st == S_DECODE) m_expand(o);
        if (h.fin && rn) m_start();
    endfunction

    logic [5:0] legal_ops [6] = '{RT, LW, SW, BQ, JP, AI};

    initial begin
        // Reset, R-type, LW with waits, SW with waits, BEQ, J, ADDI, run drops
        v(0,1,RT,1, S_IDLE,0,0);      v(1,0,RT,1, S_IDLE,0,0);
        v(1,1,RT,1, S_IDLE,0,0);      v(1,1,RT,1, S_FETCH,C_FRDY,0);
        v(1,1,RT,1, S_DECODE,C_DECODE,0); v(1,1,RT,1, S_EXEC,C_EXEC,0);
        v(1,1,RT,1, S_R_WB,C_RWB,1);
        v(1,1,LW,0, S_FETCH,C_FETCH,0); v(1,1,LW,1, S_FETCH,C_FRDY,0);
        v(1,1,LW,1, S_DECODE,C_DECODE,0); v(1,1,RT,0, S_MEM_ADDR,C_MADDR,0);
        v(1,1,RT,0, S_MEM_RD,C_MRD,0); v(1,1,RT,0, S_MEM_RD,C_MRD,0);
        v(1,1,RT,0, S_MEM_RD,C_MRD,0); v(1,1,RT,1, S_MEM_RD,C_MRD,0);
        v(1,1,RT,1, S_MEM_WB,C_MWB,1);
        v(1,1,SW,1, S_FETCH,C_FRDY,0); v(1,1,SW,1, S_DECODE,C_DECODE,0);
        v(1,1,LW,1, S_MEM_ADDR,C_MADDR,0);
        v(1,1,LW,0, S_MEM_WR,C_MWR,0); v(1,1,LW,0, S_MEM_WR,C_MWR,0);
        v(1,1,LW,0, S_MEM_WR,C_MWR,0); v(1,1,LW,1, S_MEM_WR,C_MWR,1);
        v(1,1,BQ,1, S_FETCH,C_FRDY,0); v(1,1,BQ,1, S_DECODE,C_DECODE,0);
        v(1,1,BQ,1, S_BRANCH,C_BR,1);
        v(1,1,JP,1, S_FETCH,C_FRDY,0); v(1,1,JP,1, S_DECODE,C_DECODE,0);
        v(1,1,JP,1, S_JUMP,C_J,1);
        v(1,1,AI,1, S_FETCH,C_FRDY,0); v(1,1,AI,1, S_DECODE,C_DECODE,0);
        v(1,1,AI,1, S_ADDI_EX,C_AEX,0); v(1,0,AI,1, S_ADDI_WB,C_AWB,1);
        v(1,0,RT,1, S_IDLE,0,0);       v(1,1,RT,1, S_IDLE,0,0);
        v(1,1,RT,1, S_FETCH,C_FRDY,0); v(1,1,RT,1, S_DECODE,C_DECODE,0);
        v(1,0,RT,1, S_EXEC,C_EXEC,0);  v(1,0,RT,1, S_R_WB,C_RWB,1);
        v(1,0,RT,1, S_IDLE,0,0);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].rn, tbl[i].o, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].c, tbl[i].d, 0, 0);
        end

        // Illegal opcode traps and holds until reset
        cyc(0,0,RT,1); check("ill_rst", S_IDLE, 0, 0, 0, 0);
        cyc(1,1,RT,1); check("ill_idle", S_IDLE, 0, 0, 0, 0);
        cyc(1,1,RT,1); check("ill_fetch", S_FETCH, C_FRDY, 0, 0, 0);
        cyc(1,1,6'h3F,1); check("ill_decode", S_DECODE, C_DECODE, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 6'($urandom), 1'($urandom));
            check("trap_hold", S_TRAP, 0, 0, 1, 0);
        end
        cyc(0,1,RT,1); check("ill_clear", S_IDLE, 0, 0, 0, 0);

        // Fetch stalls MEM_TIMEOUT cycles -> trap with mem_timeout
        cyc(1,1,RT,0); check("tmo_idle", S_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            cyc(1,1,RT,0); check("tmo_fetch", S_FETCH, C_FETCH, 0, 0, 0);
        end
        cyc(1,1,RT,1); check("tmo_trap", S_TRAP, 0, 0, 0, 1);
        cyc(1,1,RT,1); check("tmo_hold", S_TRAP, 0, 0, 0, 1);
        cyc(0,1,RT,0); check("tmo_clear", S_IDLE, 0, 0, 0, 0);

        // Ready in the last allowed cycle wins
        cyc(1,1,RT,0); check("edge_idle", S_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            cyc(1,1,RT,0); check("edge_fetch", S_FETCH, C_FETCH, 0, 0, 0);
        end
        cyc(1,1,RT,1); check("edge_fetch_rdy", S_FETCH, C_FRDY, 0, 0, 0);
        cyc(1,1,RT,1); check("edge_decode", S_DECODE, C_DECODE, 0, 0, 0);

        // Reset in the middle of a store drops MemWrite at once
        cyc(0,1,RT,1); check("mwr_rst0", S_IDLE, 0, 0, 0, 0);
        cyc(1,1,SW,1); check("mwr_idle", S_IDLE, 0, 0, 0, 0);
        cyc(1,1,SW,1); check("mwr_fetch", S_FETCH, C_FRDY, 0, 0, 0);
        cyc(1,1,SW,1); check("mwr_decode", S_DECODE, C_DECODE, 0, 0, 0);
        cyc(1,1,RT,0); check("mwr_addr", S_MEM_ADDR, C_MADDR, 0, 0, 0);
        cyc(1,1,RT,0); check("mwr_wait", S_MEM_WR, C_MWR, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("mwr_async_rst", S_IDLE, 0, 0, 0, 0);

        // Randomized run against the reference model
        m_reset();
        begin
            int trap_cycles;
            trap_cycles = 0;
            for (int n = 0; n < 4000; n++) begin
                bit          r, rn, rdy, ed;
                logic [5:0]  o;
                state_t      es;
                logic [15:0] ec;
                r   = !(($urandom_range(0, 299) == 0) || (trap_cycles > 8));
                rn  = ($urandom_range(0, 9) != 0);
                rdy = ($urandom_range(0, 9) < 7);
                o   = ($urandom_range(0, 11) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
                cyc(r, rn, o, rdy);
                if (!r) begin m_reset(); trap_cycles = 0; end
                if (!r || (!m_trap && mq.size() == 0)) begin
                    es = S_IDLE; ec = 0; ed = 0;
                end else if (m_trap) begin
                    es = S_TRAP; ec = 0; ed = 0;
                end else begin
                    es = mq[0].st;
                    ec = mq[0].c;
                    if (es == S_FETCH && rdy) ec = ec | C_FSTROBE;
                    ed = mq[0].fin && (!mq[0].waits || rdy);
                end
                check("rand", es, ec, ed, m_ill, m_tmo);
                if (r) m_advance(rn, o, rdy);
                if (m_trap) trap_cycles++;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
